// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ byte requesters,
// with a watchdog that abandons a grant whose tx_done never arrives.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_timeout,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_busy,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_din,
  input  logic                 i_tx_busy,
  input  logic                 i_tx_done
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t          state_q;
  logic [WD_W-1:0] wd_q;
  logic [ID_W-1:0] last_q, win_d;
  // Scan downward so the nearest requester after last_q is the final (winning) write.
  always_comb begin
    win_d = last_q;
    for (int k = NUM_REQ; k >= 1; k--)
      if (i_req[ID_W'((int'(last_q) + k) % NUM_REQ)]) win_d = ID_W'((int'(last_q) + k) % NUM_REQ);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      o_ack      <= '0;
      o_done     <= '0;
      o_timeout  <= 1'b0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_tx_din   <= '0;
      o_grant_id <= '0;
    end else begin
      o_ack      <= '0;
      o_done     <= '0;
      o_timeout  <= 1'b0;
      o_tx_start <= 1'b0;
      case (state_q)
        IDLE: if (|i_req && !i_tx_busy) begin
          state_q    <= START;
          o_busy     <= 1'b1;
          o_ack      <= NUM_REQ'(1) << win_d;
          o_tx_din   <= i_data[{win_d, 3'b000} +: 8];
          o_grant_id <= win_d;
        end
        START: begin
          state_q    <= WAIT;
          o_tx_start <= 1'b1;
          wd_q       <= '0;
        end
        WAIT: begin
          wd_q <= wd_q + WD_W'(1);
          if (i_tx_done) begin
            o_done  <= NUM_REQ'(1) << o_grant_id;
            last_q  <= o_grant_id;
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            o_timeout <= 1'b1;
            last_q    <= o_grant_id;
            state_q   <= IDLE;
            o_busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
